// File: rtl/i2c_sensor_target.sv
// I2C target exposing two config registers, a conversion-done status flag and a
// coherent RGB sample snapshot through an auto-incrementing register pointer.
module i2c_sensor_target #(
    parameter logic [6:0] DEVICE_ADDR = 7'h44
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_sda_oe,
    input  logic [15:0] i_green,
    input  logic [15:0] i_red,
    input  logic [15:0] i_blue,
    input  logic        i_data_valid,
    output logic [7:0]  o_config1,
    output logic [7:0]  o_config2,
    output logic        o_busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_prev, sda_prev;
    logic        scl, sda;
    logic        scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [7:0]  tx_byte;
    logic [7:0]  ptr;
    logic        rw_q;
    logic        ack_q;
    logic        nacked;
    logic        rd_lock;
    logic        status_done;
    logic [15:0] green_q, red_q, blue_q;
    logic [15:0] green_p, red_p, blue_p;
    logic        pend_valid;

    logic [7:0]  rd_byte;
    logic        tx_load;
    logic        byte_in;
    logic        shifting;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], i_scl};
            sda_sync <= {sda_sync[0], i_sda};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl       = scl_sync[1];
    assign sda       = sda_sync[1];
    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    assign start_det = scl & scl_prev & sda_prev & ~sda;
    assign stop_det  = scl & scl_prev & ~sda_prev & sda;

    always_comb begin
        rd_byte = '0;
        case (ptr)
            8'h01:   rd_byte = o_config1;
            8'h02:   rd_byte = o_config2;
            8'h08:   rd_byte = {6'b0, status_done, 1'b0};
            8'h09:   rd_byte = green_q[7:0];
            8'h0A:   rd_byte = green_q[15:8];
            8'h0B:   rd_byte = red_q[7:0];
            8'h0C:   rd_byte = red_q[15:8];
            8'h0D:   rd_byte = blue_q[7:0];
            8'h0E:   rd_byte = blue_q[15:8];
            default: rd_byte = '0;
        endcase
    end

    // A byte is fetched for transmission right after the address ACK of a read
    // and after every master ACK; the status flag clears on that fetch.
    assign tx_load  = scl_fall && ((state == ADDR_ACK && rw_q) || (state == RACK && !ack_q));
    assign byte_in  = scl_fall && (bit_cnt == 4'd8);
    assign shifting = (state == ADDR) || (state == PTR) || (state == WDATA);
    assign o_busy   = (state != IDLE) && (state != IGNORE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_sda_oe    <= 1'b0;
            o_config1   <= '0;
            o_config2   <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            tx_byte     <= '0;
            ptr         <= '0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b1;
            nacked      <= 1'b0;
            rd_lock     <= 1'b0;
            status_done <= 1'b0;
            green_q     <= '0;
            red_q       <= '0;
            blue_q      <= '0;
            green_p     <= '0;
            red_p       <= '0;
            blue_p      <= '0;
            pend_valid  <= 1'b0;
        end else begin
            if (i_data_valid)
                status_done <= 1'b1;
            else if (tx_load && ptr == 8'h08)
                status_done <= 1'b0;

            // Samples arriving during a read are parked and applied at STOP.
            if (i_data_valid && (!rd_lock || stop_det)) begin
                green_q    <= i_green;
                red_q      <= i_red;
                blue_q     <= i_blue;
                pend_valid <= 1'b0;
            end else if (i_data_valid) begin
                green_p    <= i_green;
                red_p      <= i_red;
                blue_p     <= i_blue;
                pend_valid <= 1'b1;
            end else if (stop_det && pend_valid) begin
                green_q    <= green_p;
                red_q      <= red_p;
                blue_q     <= blue_p;
                pend_valid <= 1'b0;
            end

            if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                o_sda_oe <= 1'b0;
                nacked   <= 1'b0;
            end else if (stop_det) begin
                state    <= IDLE;
                o_sda_oe <= 1'b0;
                rd_lock  <= 1'b0;
            end else begin
                if (shifting && scl_rise && bit_cnt != 4'd8) begin
                    shift_reg <= {shift_reg[6:0], sda};
                    bit_cnt   <= bit_cnt + 4'd1;
                end
                if (tx_load) begin
                    state    <= RDATA;
                    tx_byte  <= rd_byte;
                    o_sda_oe <= ~rd_byte[7];
                    ptr      <= ptr + 8'd1;
                    bit_cnt  <= '0;
                end else begin
                    case (state)
                        ADDR: begin
                            if (byte_in) begin
                                bit_cnt <= '0;
                                if (shift_reg[7:1] == DEVICE_ADDR) begin
                                    state    <= ADDR_ACK;
                                    o_sda_oe <= 1'b1;
                                    rw_q     <= shift_reg[0];
                                    if (shift_reg[0])
                                        rd_lock <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                        ADDR_ACK: begin
                            if (scl_fall) begin
                                state    <= PTR;
                                o_sda_oe <= 1'b0;
                            end
                        end
                        PTR: begin
                            if (byte_in) begin
                                bit_cnt  <= '0;
                                ptr      <= shift_reg;
                                state    <= PTR_ACK;
                                o_sda_oe <= 1'b1;
                            end
                        end
                        WDATA: begin
                            if (byte_in) begin
                                bit_cnt <= '0;
                                if (ptr == 8'h01)
                                    o_config1 <= shift_reg;
                                else if (ptr == 8'h02)
                                    o_config2 <= shift_reg;
                                ptr      <= ptr + 8'd1;
                                state    <= WDATA_ACK;
                                o_sda_oe <= 1'b1;
                            end
                        end
                        PTR_ACK, WDATA_ACK: begin
                            if (scl_fall) begin
                                state    <= WDATA;
                                o_sda_oe <= 1'b0;
                            end
                        end
                        RDATA: begin
                            if (!nacked && scl_fall) begin
                                if (bit_cnt == 4'd7) begin
                                    state    <= RACK;
                                    o_sda_oe <= 1'b0;
                                    bit_cnt  <= '0;
                                end else begin
                                    bit_cnt  <= bit_cnt + 4'd1;
                                    o_sda_oe <= ~tx_byte[6];
                                    tx_byte  <= {tx_byte[6:0], 1'b0};
                                end
                            end
                        end
                        RACK: begin
                            if (scl_rise)
                                ack_q <= sda;
                            else if (scl_fall) begin
                                state  <= RDATA;
                                nacked <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/i2c_sensor_target.md
I2C_SENSOR_TARGET -- requirements
Module: i2c_sensor_target

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'h44, the 7-bit target address the block answers to.
REQ-002 SHALL have port i_clk, input, 1, the single system clock; i_clk SHALL be at least 8x the SCL rate.
REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_scl, input, 1, I2C clock from the bus master.
REQ-005 SHALL have port i_sda, input, 1, I2C data as seen on the bus.
REQ-006 SHALL have port o_sda_oe, output, 1: 1 = pull SDA low, 0 = release SDA.
REQ-007 SHALL have ports i_green, i_red and i_blue, input, 16 each, the new colour sample.
REQ-008 SHALL have port i_data_valid, input, 1, a one-cycle strobe that loads a new sample.
REQ-009 SHALL have ports o_config1 and o_config2, output, 8 each, the contents of registers 0x01 and 0x02.
REQ-010 SHALL have port o_busy, output, 1, high while the block is addressed (any state other than IDLE or IGNORE).

Function
REQ-011 SHALL synchronise i_scl and i_sda through 2 flops and derive SCL rise, SCL fall, START and STOP from the synchronised values.
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
REQ-012 SHALL use the FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK and IGNORE.
REQ-013 SHALL enter ADDR and clear the bit counter on START from any state, including a repeated start.
REQ-014 SHALL enter IDLE and release SDA on STOP from any state.
REQ-015 SHALL sample SDA on SCL rise and change o_sda_oe only on SCL fall; o_sda_oe SHALL be registered.
REQ-016 SHALL shift bits in MSB first; after the 8th bit of the address byte, SHALL compare bits [7:1] with DEVICE_ADDR:
- match: ACK (o_sda_oe=1) from the following SCL fall until the SCL fall after the 9th clock;
- mismatch: enter IGNORE, never drive SDA, wait for START/STOP.
REQ-017 On a write (R/W=0), SHALL load the first data byte into the 8-bit register pointer and ACK it (PTR, PTR_ACK).
REQ-018 SHALL handle each later write byte (WDATA, WDATA_ACK) as follows:
- write it to the register at the pointer if the pointer is 0x01 or 0x02, otherwise discard it;
- ACK it in both cases;
- increment the pointer.
REQ-019 On a read (R/W=1), SHALL drive the byte at the pointer MSB first in RDATA, releasing SDA for every 1 bit and pulling it low for every 0 bit, then increment the pointer.
REQ-020 In RACK, SHALL release SDA and sample the master's bit:
- ACK (0): load the next byte and return to RDATA;
- NACK (1): release SDA and wait in RDATA-idle until START/STOP.
REQ-021 SHALL use this read map (pointer wraps 0xFF->0x00; unmapped addresses read 0x00):
- 0x01 = config1, 0x02 = config2;
- 0x08 = status, with bit1 = conversion-done flag;
- 0x09/0x0A = green low/high, 0x0B/0x0C = red low/high, 0x0D/0x0E = blue low/high.
REQ-022 SHALL set the status flag on i_data_valid and clear it when the status byte is loaded for transmission.
- If i_data_valid and that load happen in the same cycle, the flag SHALL end up set.
REQ-023 SHALL load the colour shadow registers on i_data_valid, except during a read transaction.
- During a read transaction, the sample SHALL be held pending and applied at STOP, so a 6-byte burst is always coherent.
- A newer i_data_valid SHALL overwrite a pending sample.
REQ-024 SHALL tolerate SDA changes while SCL is low, treating them as data and not as START/STOP.

Reset
REQ-025 While i_rst_n=0, SHALL hold:
- state IDLE;
- o_sda_oe=0, o_busy=0;
- o_config1=o_config2=0x00, status=0x00, pointer=0x00;
- all colour shadow registers and the pending sample = 0.
REQ-026 SHALL abort any transfer on reset mid-transfer and release SDA within 0 cycles (asynchronous).
REQ-027 After reset release, SHALL ignore bus activity until the first START.

Verification
REQ-028 Write 0x88, 0x01, 0x0D, 0x3F, STOP -> all bytes ACKed; o_config1=0x0D, o_config2=0x3F.
REQ-029 i_data_valid with G=0x1234, R=0x5678, B=0x9ABC, then write 0x88, 0x08; repeated start; read 0x89 with 7 bytes -> 0x02, 0x34, 0x12, 0x78, 0x56, 0xBC, 0x9A; master NACKs the last byte; a re-read of 0x08 -> 0x00.
REQ-030 Address 0x8A (addr 0x45) -> o_sda_oe stays 0 for the whole transfer; o_busy=0; registers unchanged.
REQ-031 i_data_valid with G=0xFFFF during a burst read of 0x09..0x0E -> the old values are returned; after STOP, a new read returns 0xFF, 0xFF.
REQ-032 Assert i_rst_n=0 in the middle of the ACK bit of the address byte -> o_sda_oe=0 immediately; o_config1=0x00.
REQ-033 Write the pointer 0xFF, then read 2 bytes -> 0x00, 0x00 (the pointer wraps to 0x00).
